// File: rtl/vtg_telemetry_framer_if.sv
// Byte-serial telemetry stream carrying one framed window summary.
// The framer drives data/valid (master); the sink drives ready (slave).
interface vtg_telemetry_framer_if;
  logic [7:0] frame_data;
  logic       frame_valid;
  logic       frame_ready;

  modport master (
    output frame_data,
    output frame_valid,
    input  frame_ready
  );

  modport slave (
    input  frame_data,
    input  frame_valid,
    output frame_ready
  );
endinterface

// File: rtl/vtg_telemetry_framer.sv
// vtg_telemetry_framer: accumulates 2^WINDOW_LOG2 voltage samples, snapshots
// min/max/mean per window and emits them as a byte-serial frame
// (0xA5, seq, min, max, avg[, chk]).  Capture keeps running while a frame
// drains; a window that completes while the previous frame is still busy is
// dropped and flagged through the sticky overrun output.
// Optional feature: define VTG_FRAME_CHECKSUM_EN to append the XOR checksum
// byte (seq ^ min ^ max ^ avg) as a sixth byte.
module vtg_telemetry_framer #(
  parameter int WINDOW_LOG2 = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    sample_in,
  input  logic                          sample_valid,
  vtg_telemetry_framer_if.master        frame_if,
  output logic                          busy,
  output logic                          overrun,
  input  logic                          clear_overrun
);

  localparam int SW = 8 + WINDOW_LOG2;

`ifdef VTG_FRAME_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_SEQ, S_MIN, S_MAX, S_AVG, S_CHK} state_t;
  localparam state_t LAST_STATE = S_CHK;
`else
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_SEQ, S_MIN, S_MAX, S_AVG} state_t;
  localparam state_t LAST_STATE = S_AVG;
`endif

  state_t state_q, state_d;

  logic [SW-1:0]          sum_q;
  logic [7:0]             min_q;
  logic [7:0]             max_q;
  logic [WINDOW_LOG2-1:0] cnt_q;

  logic [7:0] seq_q;
  logic [7:0] snap_seq_q;
  logic [7:0] snap_min_q;
  logic [7:0] snap_max_q;
  logic [7:0] snap_avg_q;
  logic       overrun_q;

  logic [SW-1:0] sum_upd;
  logic [7:0]    min_upd;
  logic [7:0]    max_upd;
  logic          win_done;
  logic          last_hs;
  logic          load;
  logic          frame_valid_int;
  logic [7:0]    frame_data_int;

  // Accumulator values including the current sample, plus window/load decisions.
  always_comb begin
    sum_upd  = sum_q + {{WINDOW_LOG2{1'b0}}, sample_in};
    min_upd  = (sample_in < min_q) ? sample_in : min_q;
    max_upd  = (sample_in > max_q) ? sample_in : max_q;
    win_done = sample_valid && (cnt_q == {WINDOW_LOG2{1'b1}});
    // The final byte being accepted frees the snapshot on this same edge.
    last_hs  = (state_q == LAST_STATE) && frame_if.frame_ready;
    load     = win_done && ((state_q == S_IDLE) || last_hs);
  end

  // Window accumulators; reinitialised on the completing sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
      min_q <= 8'hFF;
      max_q <= 8'h00;
      cnt_q <= '0;
    end else if (sample_valid) begin
      if (win_done) begin
        sum_q <= '0;
        min_q <= 8'hFF;
        max_q <= 8'h00;
        cnt_q <= '0;
      end else begin
        sum_q <= sum_upd;
        min_q <= min_upd;
        max_q <= max_upd;
        cnt_q <= cnt_q + {{(WINDOW_LOG2-1){1'b0}}, 1'b1};
      end
    end
  end

  // Snapshot of a completed window; only loaded when the frame path is free.
  always_ff @(posedge clk) begin
    if (rst) begin
      seq_q      <= 8'h00;
      snap_seq_q <= 8'h00;
      snap_min_q <= 8'h00;
      snap_max_q <= 8'h00;
      snap_avg_q <= 8'h00;
    end else if (load) begin
      seq_q      <= seq_q + 8'h01;
      snap_seq_q <= seq_q;
      snap_min_q <= min_upd;
      snap_max_q <= max_upd;
      snap_avg_q <= sum_upd[SW-1:WINDOW_LOG2];
    end
  end

  // Sticky overrun: a dropped window sets it, and setting beats clearing.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else if (win_done && !load) begin
      overrun_q <= 1'b1;
    end else if (clear_overrun) begin
      overrun_q <= 1'b0;
    end
  end

  // Frame FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame FSM next state: one byte per accepted handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (load) state_d = S_HDR;
      S_HDR:  if (frame_if.frame_ready) state_d = S_SEQ;
      S_SEQ:  if (frame_if.frame_ready) state_d = S_MIN;
      S_MIN:  if (frame_if.frame_ready) state_d = S_MAX;
      S_MAX:  if (frame_if.frame_ready) state_d = S_AVG;
`ifdef VTG_FRAME_CHECKSUM_EN
      S_AVG:  if (frame_if.frame_ready) state_d = S_CHK;
      S_CHK:  if (frame_if.frame_ready) state_d = load ? S_HDR : S_IDLE;
`else
      S_AVG:  if (frame_if.frame_ready) state_d = load ? S_HDR : S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Frame byte selection from the stable snapshot.
  always_comb begin
    frame_valid_int = (state_q != S_IDLE);
    frame_data_int  = 8'h00;
    case (state_q)
      S_HDR: frame_data_int = 8'hA5;
      S_SEQ: frame_data_int = snap_seq_q;
      S_MIN: frame_data_int = snap_min_q;
      S_MAX: frame_data_int = snap_max_q;
      S_AVG: frame_data_int = snap_avg_q;
`ifdef VTG_FRAME_CHECKSUM_EN
      S_CHK: frame_data_int = snap_seq_q ^ snap_min_q ^ snap_max_q ^ snap_avg_q;
`endif
      default: frame_data_int = 8'h00;
    endcase
  end

  assign frame_if.frame_data  = frame_data_int;
  assign frame_if.frame_valid = frame_valid_int;
  assign busy                 = frame_valid_int;
  assign overrun              = overrun_q;

endmodule

// File: tb/tb_vtg_telemetry_framer.sv
// Bench for vtg_telemetry_framer (WINDOW_LOG2=3): table of windows with
// hand-computed statistics, hand-written corner sequences, and a randomized
// run checked every cycle against a queue-based frame model.
module tb_vtg_telemetry_framer;

  localparam int W = 3;
  localparam int N = 1 << W;
`ifdef VTG_FRAME_CHECKSUM_EN
  localparam int FLEN = 6;
`else
  localparam int FLEN = 5;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic       clear_overrun;
  logic       busy;
  logic       overrun;

  vtg_telemetry_framer_if fif();

  vtg_telemetry_framer #(.WINDOW_LOG2(W)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .sample_in     (sample_in),
    .sample_valid  (sample_valid),
    .frame_if      (fif),
    .busy          (busy),
    .overrun       (overrun),
    .clear_overrun (clear_overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: bytes still to be sent, samples of the open window.
  byte unsigned pend[$];
  byte unsigned win[$];
  byte unsigned rx[$];
  byte unsigned m_seq;
  bit           m_ovr;

  typedef struct packed {
    logic [7:0][7:0] s;
    logic [7:0]      mn;
    logic [7:0]      mx;
    logic [7:0]      av;
  } vec_t;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(bit r, bit sv, byte unsigned s, bit rdy, bit clr);
    bit set;
    int sm;
    byte unsigned mn, mx, av;
    if (r) begin
      pend.delete();
      win.delete();
      m_seq = 8'h00;
      m_ovr = 1'b0;
      return;
    end
    set = 1'b0;
    if (rdy && pend.size() > 0) void'(pend.pop_front());
    if (sv) begin
      win.push_back(s);
      if (win.size() == N) begin
        if (pend.size() == 0) begin
          mn = 8'hFF; mx = 8'h00; sm = 0;
          foreach (win[k]) begin
            if (win[k] < mn) mn = win[k];
            if (win[k] > mx) mx = win[k];
            sm += win[k];
          end
          av = byte'(sm / N);
          pend.push_back(8'hA5);
          pend.push_back(m_seq);
          pend.push_back(mn);
          pend.push_back(mx);
          pend.push_back(av);
`ifdef VTG_FRAME_CHECKSUM_EN
          pend.push_back(m_seq ^ mn ^ mx ^ av);
`endif
          m_seq++;
        end else begin
          set = 1'b1;
        end
        win.delete();
      end
    end
    if (set) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
  endtask

  // One clock: log accepted byte, advance the model, compare all outputs.
  task automatic tick();
    bit r, sv, rdy, clr;
    byte unsigned s;
    r = rst; sv = sample_valid; s = sample_in; rdy = fif.frame_ready; clr = clear_overrun;
    if (!r && fif.frame_valid && rdy) rx.push_back(fif.frame_data);
    @(posedge clk);
    #1;
    model_step(r, sv, s, rdy, clr);
    check("model_valid", int'(fif.frame_valid), int'(pend.size() > 0));
    check("model_data", int'(fif.frame_data), (pend.size() > 0) ? int'(pend[0]) : 0);
    check("model_busy", int'(busy), int'(pend.size() > 0));
    check("model_overrun", int'(overrun), int'(m_ovr));
  endtask

  task automatic cyc(bit sv, byte unsigned s, bit rdy, bit clr);
    sample_valid = sv;
    sample_in = s;
    fif.frame_ready = rdy;
    clear_overrun = clr;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    rst = 1'b0;
  endtask

  vec_t tbl[5];

  initial begin
    rst = 1'b1;
    sample_in = 8'h00;
    sample_valid = 1'b0;
    clear_overrun = 1'b0;
    fif.frame_ready = 1'b0;

    tbl[0].s = {8'd10, 8'd20, 8'd30, 8'd41, 8'd10, 8'd20, 8'd30, 8'd41};
    tbl[0].mn = 8'h0A; tbl[0].mx = 8'h29; tbl[0].av = 8'h19;
    tbl[1].s = {8{8'hFF}};
    tbl[1].mn = 8'hFF; tbl[1].mx = 8'hFF; tbl[1].av = 8'hFF;
    tbl[2].s = {8{8'h00}};
    tbl[2].mn = 8'h00; tbl[2].mx = 8'h00; tbl[2].av = 8'h00;
    tbl[3].s = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    tbl[3].mn = 8'h01; tbl[3].mx = 8'h08; tbl[3].av = 8'h04;
    tbl[4].s = {8'd200, 8'd100, 8'd50, 8'd25, 8'd12, 8'd6, 8'd3, 8'd1};
    tbl[4].mn = 8'h01; tbl[4].mx = 8'hC8; tbl[4].av = 8'h31;

    // Reset values.
    do_reset();
    check("rst_valid", int'(fif.frame_valid), 0);
    check("rst_data", int'(fif.frame_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);

    // Table windows back-to-back with ready high.
    rx.delete();
    for (int i = 0; i < 5; i++) begin
      for (int k = 7; k >= 0; k--) cyc(1, tbl[i].s[k], 1, 0);
      if (i == 0) begin
        check("latency_valid", int'(fif.frame_valid), 1);
        check("latency_hdr", int'(fif.frame_data), 8'hA5);
      end
    end
    for (int k = 0; k < FLEN + 2; k++) cyc(0, 0, 1, 0);
    check("tbl_bytes", rx.size(), 5 * FLEN);
    for (int i = 0; i < 5; i++) begin
      check("tbl_hdr", int'(rx[i*FLEN]), 8'hA5);
      check("tbl_seq", int'(rx[i*FLEN+1]), i);
      check("tbl_min", int'(rx[i*FLEN+2]), int'(tbl[i].mn));
      check("tbl_max", int'(rx[i*FLEN+3]), int'(tbl[i].mx));
      check("tbl_avg", int'(rx[i*FLEN+4]), int'(tbl[i].av));
`ifdef VTG_FRAME_CHECKSUM_EN
      check("tbl_chk", int'(rx[i*FLEN+5]), int'(i[7:0] ^ tbl[i].mn ^ tbl[i].mx ^ tbl[i].av));
`endif
    end
    check("tbl_no_overrun", int'(overrun), 0);

    // Stalled sink: two more windows are dropped, first frame held.
    do_reset();
    rx.delete();
    for (int k = 0; k < N; k++) cyc(1, byte'(k * 3), 1, 0);
    for (int k = 0; k < 2 * N; k++) cyc(1, byte'(k), 0, 0);
    check("stall_overrun", int'(overrun), 1);
    check("stall_hdr_held", int'(fif.frame_data), 8'hA5);
    for (int k = 0; k < FLEN + 1; k++) cyc(0, 0, 1, 0);
    check("stall_seq0", int'(rx[1]), 0);
    check("stall_min", int'(rx[2]), 0);
    check("stall_max", int'(rx[3]), 21);
    rx.delete();
    for (int k = 0; k < N; k++) cyc(1, 8'h40, 1, 0);
    for (int k = 0; k < FLEN + 1; k++) cyc(0, 0, 1, 0);
    check("stall_seq1", int'(rx[1]), 1);

    // Set and clear of overrun on the same edge: set wins; clear alone clears.
    for (int k = 0; k < N; k++) cyc(1, 8'h11, 0, 0);
    for (int k = 0; k < N; k++) cyc(1, 8'h22, 0, 1);
    check("ovr_set_wins", int'(overrun), 1);
    cyc(0, 0, 0, 1);
    check("ovr_clear", int'(overrun), 0);

    // Reset during the MIN byte; partial window is discarded too.
    do_reset();
    for (int k = 0; k < N; k++) cyc(1, byte'(50 + 10 * k), 0, 0);
    cyc(1, 8'h05, 1, 0);
    cyc(1, 8'h06, 1, 0);
    check("mid_min_byte", int'(fif.frame_data), 8'h32);
    rst = 1'b1;
    cyc(1, 8'h07, 0, 0);
    rst = 1'b0;
    check("mid_rst_valid", int'(fif.frame_valid), 0);
    check("mid_rst_busy", int'(busy), 0);
    rx.delete();
    for (int k = 0; k < N; k++) cyc(1, 8'h09, 1, 0);
    for (int k = 0; k < FLEN + 1; k++) cyc(0, 0, 1, 0);
    check("mid_rst_frames", rx.size(), FLEN);
    check("mid_rst_seq", int'(rx[1]), 0);

    // Continuous full-rate samples: back-to-back frames, seq wraps.
    do_reset();
    rx.delete();
    for (int k = 0; k < 260 * N; k++) cyc(1, byte'($urandom_range(0, 255)), 1, 0);
    for (int k = 0; k < FLEN + 1; k++) cyc(0, 0, 1, 0);
    check("cont_frames", rx.size(), 260 * FLEN);
    check("cont_no_overrun", int'(overrun), 0);
    check("cont_seq_ff", int'(rx[255*FLEN+1]), 8'hFF);
    check("cont_seq_wrap", int'(rx[256*FLEN+1]), 8'h00);

    // Randomized traffic against the model.
    do_reset();
    for (int k = 0; k < 6000; k++) begin
      rst = ($urandom_range(0, 999) == 0);
      cyc($urandom_range(0, 3) != 0, byte'($urandom_range(0, 255)),
          $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
